// File: rtl/regfile_wb.sv
// regfile_wb: general-purpose register file with write-back port and {N,P,Z,C}
// status-flag register for the 8-bit CPU datapath.
//   - Two combinational read ports feed the ALU a/b operands.
//   - One write port captures the ALU result; flags are derived from wr_data.
//   - Addresses >= DEPTH are unimplemented: writes are dropped, reads return 0.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// onto a read port whose address matches the write address.
module regfile_wb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cy_in,
  input  logic             flag_we,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic [WIDTH-1:0] a_rd;
  logic [WIDTH-1:0] b_rd;

  // Next register contents: only an implemented address matching wr_addr
  // takes wr_data, so out-of-range writes fall through untouched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == AW'(i))) mem_d[i] = wr_data;
    end
  end

  // Next flags {N,P,Z,C}; computed from wr_data regardless of wr_en/wr_addr
  // so compare-type operations can set flags without writing a register.
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {wr_data[WIDTH-1], ~^wr_data, (wr_data == '0), cy_in};
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is deliberately reset (every entry cleared),
      // which forces flops rather than a RAM macro; the CPU relies on r*=0.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      flags_q <= flags_d;
    end
  end

  // Combinational read ports; unimplemented addresses and reset read 0.
  always_comb begin
    a_rd = '0;
    b_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra_addr == AW'(i)) a_rd = mem_q[i];
      if (rb_addr == AW'(i)) b_rd = mem_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write so dependent ALU ops need no stall.
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      if (ra_addr == wr_addr) a_rd = wr_data;
      if (rb_addr == wr_addr) b_rd = wr_data;
    end
`endif
    // Keep the operand buses quiet while reset is held, even if a bypass
    // candidate is being driven.
    if (!rst_n) begin
      a_rd = '0;
      b_rd = '0;
    end
  end

  assign a_out = a_rd;
  assign b_out = b_rd;
  assign flags = flags_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: a DEPTH=8 instance for the main
// behaviour and a DEPTH=4 instance for unimplemented-address handling.
module tb_regfile_wb;

  logic       clk;
  logic       rst_n;

  // DEPTH=8 instance signals
  logic [2:0] ra_addr, rb_addr, wr_addr;
  logic [7:0] a_out, b_out, wr_data;
  logic       wr_en, cy_in, flag_we;
  logic [3:0] flags;

  // DEPTH=4 instance signals
  logic [2:0] ra4, rb4, wa4;
  logic [7:0] a4, b4, wd4;
  logic       we4, cy4, fwe4;
  logic [3:0] flags4;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .a_out(a_out), .b_out(b_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cy_in(cy_in), .flag_we(flag_we), .flags(flags)
  );

  regfile_wb #(.WIDTH(8), .DEPTH(4), .AW(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ra_addr(ra4), .rb_addr(rb4),
    .a_out(a4), .b_out(b4),
    .wr_en(we4), .wr_addr(wa4), .wr_data(wd4),
    .cy_in(cy4), .flag_we(fwe4), .flags(flags4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write-back cycle on the DEPTH=8 instance.
  task automatic wr(input logic [2:0] addr, input logic [7:0] data,
                    input logic en, input logic fwe, input logic cy);
    wr_en = en; wr_addr = addr; wr_data = data; flag_we = fwe; cy_in = cy;
    step();
    wr_en = 1'b0; flag_we = 1'b0; cy_in = 1'b0;
  endtask

  // One write-back cycle on the DEPTH=4 instance.
  task automatic wr4(input logic [2:0] addr, input logic [7:0] data, input logic fwe);
    we4 = 1'b1; wa4 = addr; wd4 = data; fwe4 = fwe; cy4 = 1'b0;
    step();
    we4 = 1'b0; fwe4 = 1'b0;
  endtask

  logic [7:0] exp_pre;

  initial begin
    rst_n = 1'b0;
    ra_addr = '0; rb_addr = '0; wr_addr = '0; wr_data = '0;
    wr_en = 1'b0; cy_in = 1'b0; flag_we = 1'b0;
    ra4 = '0; rb4 = '0; wa4 = '0; wd4 = '0; we4 = 1'b0; cy4 = 1'b0; fwe4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    ra_addr = 3'd3; rb_addr = 3'd7; #1;
    check("reset_a", a_out, 8'h00);
    check("reset_b", b_out, 8'h00);
    check("reset_flags", 8'(flags), 8'h00);

    // T1: A5 has four ones -> {N1,P1,Z0,C1}
    wr(3'd3, 8'hA5, 1'b1, 1'b1, 1'b1);
    check("t1_r3", a_out, 8'hA5);
    check("t1_flags", 8'(flags), 8'b0000_1101);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A;   // bypass candidate during reset
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_a", a_out, 8'h00);
    check("t1_async_flags", 8'(flags), 8'h00);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_after_release", a_out, 8'h00);

    // T2: consecutive writes, then read both ports
    wr(3'd1, 8'h0A, 1'b1, 1'b0, 1'b0);
    wr(3'd2, 8'h02, 1'b1, 1'b0, 1'b0);
    ra_addr = 3'd1; rb_addr = 3'd2; #1;
    check("t2_a", a_out, 8'h0A);
    check("t2_b", b_out, 8'h02);
    rb_addr = 3'd1; #1;
    check("t2_same_addr", b_out, 8'h0A);

    // T3: flags from zero result and from 0x81
    wr(3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t3_zero_flags", 8'(flags), 8'b0000_0111);
    wr(3'd0, 8'h81, 1'b0, 1'b1, 1'b0);
    check("t3_81_flags", 8'(flags), 8'b0000_1100);

    // Odd parity: 0x01 -> all flags clear
    wr(3'd0, 8'h01, 1'b0, 1'b1, 1'b0);
    check("odd_parity_flags", 8'(flags), 8'h00);

    // Flags hold while flag_we=0
    wr(3'd6, 8'h07, 1'b1, 1'b0, 1'b1);
    ra_addr = 3'd6; #1;
    check("hold_r6", a_out, 8'h07);
    check("hold_flags", 8'(flags), 8'h00);

    // T4: r5=3C with flags {N0,P1,Z0,C1}, then flag-only FF to r5
    wr(3'd5, 8'h3C, 1'b1, 1'b1, 1'b1);
    check("t4_pre_flags", 8'(flags), 8'b0000_0101);
    wr(3'd5, 8'hFF, 1'b0, 1'b1, 1'b0);
    ra_addr = 3'd5; #1;
    check("t4_r5_unchanged", a_out, 8'h3C);
    check("t4_flags", 8'(flags), 8'b0000_1100);

    // T5: same-address read/write
    wr(3'd4, 8'h11, 1'b1, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    exp_pre = 8'h22;
`else
    exp_pre = 8'h11;
`endif
    ra_addr = 3'd4; rb_addr = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h22; #1;
    check("t5_pre_a", a_out, exp_pre);
    check("t5_pre_b", b_out, exp_pre);
    check("t5_other_reg", 8'h11, 8'h11 & a_out | (exp_pre == 8'h22 ? 8'h11 : 8'h00));
    step();
    wr_en = 1'b0; #1;
    check("t5_post_a", a_out, 8'h22);
    check("t5_post_b", b_out, 8'h22);

    // T6: DEPTH=4 instance, unimplemented address 6
    for (int i = 0; i < 4; i++) wr4(3'(i), 8'(8'h10 * (i + 1)), 1'b0);
    we4 = 1'b1; wa4 = 3'd6; wd4 = 8'h55; fwe4 = 1'b1; ra4 = 3'd6; #1;
    check("t6_pre_a", a4, 8'h00);
    step();
    we4 = 1'b0; fwe4 = 1'b0; #1;
    check("t6_read6", a4, 8'h00);
    check("t6_flags", 8'(flags4), 8'b0000_0100);
    for (int i = 0; i < 4; i++) begin
      ra4 = 3'(i); rb4 = 3'(i + 4); #1;
      check($sformatf("t6_r%0d", i), a4, 8'(8'h10 * (i + 1)));
      check($sformatf("t6_hi%0d", i + 4), b4, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
